// File: rtl/segseven_pkg.sv
// Shared 7-segment code table and pattern-to-digit decoder.
// Bit 0 = segment a ... bit 6 = segment g, 1 = lit.
package segseven_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7C;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] DIGIT_NONE = 4'hF;

    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       error;
    } seg_rec_t;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } dec_state_t;

    function automatic seg_rec_t seg_to_digit(input logic [6:0] pattern);
        seg_rec_t rec;
        rec.digit = DIGIT_NONE;
        rec.blank = 1'b0;
        rec.error = 1'b0;
        case (pattern)
            SEG_0:     rec.digit = 4'd0;
            SEG_1:     rec.digit = 4'd1;
            SEG_2:     rec.digit = 4'd2;
            SEG_3:     rec.digit = 4'd3;
            SEG_4:     rec.digit = 4'd4;
            SEG_5:     rec.digit = 4'd5;
            SEG_6:     rec.digit = 4'd6;
            SEG_7:     rec.digit = 4'd7;
            SEG_8:     rec.digit = 4'd8;
            SEG_9:     rec.digit = 4'd9;
            SEG_BLANK: rec.blank = 1'b1;
            default:   rec.error = 1'b1;
        endcase
        return rec;
    endfunction

endpackage

// File: rtl/segseven_decode_if.sv
// Ready/valid record channel carrying one decoded display pattern.
interface segseven_decode_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_blank;
    logic       out_error;

    modport master (
        output out_valid,
        output out_digit,
        output out_blank,
        output out_error,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_digit,
        input  out_blank,
        input  out_error,
        output out_ready
    );
endinterface

// File: rtl/segseven_sync_filter.sv
// Two-flop synchronizer plus run-length glitch filter on the segment bus.
// stable is high once sync has repeated STABLE_CYCLES times in a row.
module segseven_sync_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [6:0] sync,
    output logic       stable
);

    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

    logic [6:0] meta_reg;
    logic [6:0] sync_reg;
    logic [7:0] run_reg;

    // The run counter looks at the sample about to enter sync, so a
    // difference restarts the count on the same edge sync changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
            run_reg  <= '0;
        end else begin
            meta_reg <= seg_in;
            sync_reg <= meta_reg;
            if (meta_reg != sync_reg)
                run_reg <= '0;
            else if (run_reg != RUN_MAX)
                run_reg <= run_reg + 8'd1;
        end
    end

    assign sync   = sync_reg;
    assign stable = (run_reg == RUN_MAX);

endmodule

// File: rtl/segseven_decode.sv
// Recovers the digit shown on a looped-back 7-segment bus and offers each
// newly stable pattern as a ready/valid record; latest pattern wins on stall.
module segseven_decode
    import segseven_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_in,
    segseven_decode_if.master         rec,
    output logic [7:0]                err_count
);

    logic [6:0] sync;
    logic       stable;
    seg_rec_t   dec;
    logic       accept;

    dec_state_t state_reg;
    logic       valid_reg;
    logic [6:0] last_pat_reg;
    logic [3:0] digit_reg;
    logic       blank_reg;
    logic       error_reg;
    logic [7:0] err_count_reg;

    segseven_sync_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .seg_in (seg_in),
        .sync   (sync),
        .stable (stable)
    );

    assign dec    = seg_to_digit(sync);
    assign accept = stable && (sync != last_pat_reg) &&
                    ((state_reg == ST_IDLE) || rec.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            valid_reg     <= 1'b0;
            last_pat_reg  <= SEG_BLANK;
            digit_reg     <= DIGIT_NONE;
            blank_reg     <= 1'b0;
            error_reg     <= 1'b0;
            err_count_reg <= '0;
        end else if (accept) begin
            state_reg    <= ST_HOLD;
            valid_reg    <= 1'b1;
            last_pat_reg <= sync;
            digit_reg    <= dec.digit;
            blank_reg    <= dec.blank;
            error_reg    <= dec.error;
            if (dec.error && (err_count_reg != 8'hFF))
                err_count_reg <= err_count_reg + 8'd1;
        end else if ((state_reg == ST_HOLD) && rec.out_ready) begin
            state_reg <= ST_IDLE;
            valid_reg <= 1'b0;
        end
    end

    assign rec.out_valid = valid_reg;
    assign rec.out_digit = digit_reg;
    assign rec.out_blank = blank_reg;
    assign rec.out_error = error_reg;
    assign err_count     = err_count_reg;

endmodule

// File: tb/tb_segseven_decode.sv
// Directed bench for segseven_decode: latency, glitch filter, code sweep,
// error saturation, stall/back-to-back and asynchronous reset.
module tb_segseven_decode;
    import segseven_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [7:0] err_count;
    int         checks;
    int         errors;
    seg_rec_t   rec_q[$];

    segseven_decode_if bus ();

    segseven_decode #(
        .STABLE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .rec       (bus),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every completed handshake.
    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            rec_q.push_back({bus.out_digit, bus.out_blank, bus.out_error});
            $display("record digit=%0h blank=%0b error=%0b err_count=%0d",
                     bus.out_digit, bus.out_blank, bus.out_error, err_count);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        seg_in = 7'h00;
        bus.out_ready = 1'b0;
        step(3);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_digit !== 4'hF) begin
            errors++; $display("FAIL reset_digit: got %0h expected f", bus.out_digit);
        end
        checks++;
        if (bus.out_blank !== 1'b0 || bus.out_error !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got blank=%0b error=%0b expected 0 0",
                               bus.out_blank, bus.out_error);
        end
        checks++;
        if (err_count !== 8'd0) begin
            errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count);
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_latency;
        rec_q.delete();
        bus.out_ready = 1'b1;
        seg_in = 7'h5B;
        step(6);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL latency_edge5: got valid=%0b expected 0", bus.out_valid);
        end
        step(1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd2 ||
            bus.out_blank !== 1'b0 || bus.out_error !== 1'b0) begin
            errors++; $display("FAIL latency_edge6: got valid=%0b digit=%0h blank=%0b error=%0b expected 1 2 0 0",
                               bus.out_valid, bus.out_digit, bus.out_blank, bus.out_error);
        end
        step(10);
        checks++;
        if (rec_q.size() != 1) begin
            errors++; $display("FAIL latency_count: got %0d records expected 1", rec_q.size());
        end
    endtask

    task automatic test_glitch;
        seg_in = 7'h00;
        step(12);
        rec_q.delete();
        seg_in = 7'h06;
        step(3);
        seg_in = 7'h00;
        step(12);
        checks++;
        if (rec_q.size() != 0) begin
            errors++; $display("FAIL glitch_records: got %0d expected 0", rec_q.size());
        end
        checks++;
        if (err_count !== 8'd0) begin
            errors++; $display("FAIL glitch_err_count: got %0d expected 0", err_count);
        end
    endtask

    task automatic test_sweep;
        logic [6:0] codes [10];
        codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07, 7'h7F, 7'h67};
        rec_q.delete();
        for (int i = 0; i < 10; i++) begin
            seg_in = codes[i];
            step(10);
        end
        seg_in = 7'h00;
        step(10);
        checks++;
        if (rec_q.size() != 11) begin
            errors++; $display("FAIL sweep_count: got %0d expected 11", rec_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rec_q[i].digit !== 4'(i) || rec_q[i].blank !== 1'b0 || rec_q[i].error !== 1'b0) begin
                    errors++; $display("FAIL sweep_digit%0d: got digit=%0h blank=%0b error=%0b expected %0h 0 0",
                                       i, rec_q[i].digit, rec_q[i].blank, rec_q[i].error, i);
                end
            end
            checks++;
            if (rec_q[10].digit !== 4'hF || rec_q[10].blank !== 1'b1 || rec_q[10].error !== 1'b0) begin
                errors++; $display("FAIL sweep_blank: got digit=%0h blank=%0b error=%0b expected f 1 0",
                                   rec_q[10].digit, rec_q[10].blank, rec_q[10].error);
            end
        end
        checks++;
        if (err_count !== 8'd0) begin
            errors++; $display("FAIL sweep_err_count: got %0d expected 0", err_count);
        end
    endtask

    task automatic test_invalid;
        int exp_err;
        rec_q.delete();
        seg_in = 7'h7E;
        step(10);
        exp_err = 1;
        checks++;
        if (rec_q.size() != 1 || rec_q[0].error !== 1'b1 ||
            rec_q[0].digit !== 4'hF || rec_q[0].blank !== 1'b0) begin
            errors++; $display("FAIL invalid_record: got %0d records (first digit=%0h error=%0b) expected 1 (f 1)",
                               rec_q.size(), rec_q.size() > 0 ? rec_q[0].digit : 4'h0,
                               rec_q.size() > 0 ? rec_q[0].error : 1'b0);
        end
        checks++;
        if (err_count !== 8'd1) begin
            errors++; $display("FAIL invalid_err_count: got %0d expected 1", err_count);
        end
        for (int i = 0; i < 300; i++) begin
            seg_in = 7'h3F;
            step(8);
            seg_in = 7'h7E;
            step(8);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            if (i == 252) begin
                checks++;
                if (err_count !== 8'(exp_err)) begin
                    errors++; $display("FAIL err_count_254: got %0d expected %0d", err_count, exp_err);
                end
            end
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++; $display("FAIL err_count_saturate: got %0d expected 255", err_count);
        end
    endtask

    task automatic test_stall;
        bus.out_ready = 1'b0;
        rec_q.delete();
        seg_in = 7'h4F;
        step(10);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd3) begin
            errors++; $display("FAIL stall_first: got valid=%0b digit=%0h expected 1 3",
                               bus.out_valid, bus.out_digit);
        end
        seg_in = 7'h6D;
        step(10);
        seg_in = 7'h07;
        step(10);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd3 || rec_q.size() != 0) begin
            errors++; $display("FAIL stall_hold: got valid=%0b digit=%0h records=%0d expected 1 3 0",
                               bus.out_valid, bus.out_digit, rec_q.size());
        end
        bus.out_ready = 1'b1;
        step(1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd7) begin
            errors++; $display("FAIL back_to_back: got valid=%0b digit=%0h expected 1 7",
                               bus.out_valid, bus.out_digit);
        end
        step(5);
        checks++;
        if (rec_q.size() != 2 || rec_q[0].digit !== 4'd3 || rec_q[1].digit !== 4'd7) begin
            errors++; $display("FAIL stall_order: got %0d records (%0h,%0h) expected 2 (3,7)",
                               rec_q.size(), rec_q.size() > 0 ? rec_q[0].digit : 4'h0,
                               rec_q.size() > 1 ? rec_q[1].digit : 4'h0);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_idle: got valid=%0b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1'b0;
        seg_in = 7'h66;
        step(10);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd4) begin
            errors++; $display("FAIL midrst_before: got valid=%0b digit=%0h expected 1 4",
                               bus.out_valid, bus.out_digit);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_async: got valid=%0b expected 0", bus.out_valid);
        end
        step(2);
        rec_q.delete();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step(6);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_edge5: got valid=%0b expected 0", bus.out_valid);
        end
        step(1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd4) begin
            errors++; $display("FAIL midrst_reemit: got valid=%0b digit=%0h expected 1 4",
                               bus.out_valid, bus.out_digit);
        end
        step(5);
        checks++;
        if (rec_q.size() != 1) begin
            errors++; $display("FAIL midrst_count: got %0d records expected 1", rec_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        seg_in = 7'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_sweep();
        test_invalid();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
